// File: rtl/uart_baud_tick_gen.sv
// Fractional-N baud tick generator: independent TX (bit tick) and RX (oversample tick)
// prescaler channels sharing one shadow divisor that each channel adopts at a period boundary.
module uart_baud_tick_gen #(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OVERSAMPLE   = 16,
   parameter int DEF_DIV_INT  = 325,
   parameter int DEF_DIV_FRAC = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_load,
   input  logic [DIV_W-1:0]  cfg_div_int,
   input  logic [FRAC_W-1:0] cfg_div_frac,
   input  logic              rx_resync,
   output logic              tx_tick,
   output logic              rx_os_tick,
   output logic              cfg_err,
   output logic [DIV_W-1:0]  cur_div_int,
   output logic [FRAC_W-1:0] cur_div_frac
);

   localparam int                S_W      = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV_INT);
   localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV_FRAC);
   localparam logic [S_W-1:0]    S_LAST   = S_W'(OVERSAMPLE - 1);

   // Terminal prescaler count N-1, one bit wider than p so div_int = 2^DIV_W-1 plus carry fits.
   function automatic logic [DIV_W:0] last_count(input logic [DIV_W-1:0]  div_int,
                                                 input logic [FRAC_W-1:0] div_frac,
                                                 input logic [FRAC_W-1:0] acc);
      logic [FRAC_W:0] sum;
      sum = {1'b0, acc} + {1'b0, div_frac};
      return {1'b0, div_int} + {{DIV_W{1'b0}}, sum[FRAC_W]} - {{DIV_W{1'b0}}, 1'b1};
   endfunction

   logic              cfg_ok;
   logic [DIV_W-1:0]  shadow_int, shadow_int_nxt;
   logic [FRAC_W-1:0] shadow_frac, shadow_frac_nxt;

   logic [DIV_W-1:0]  tx_int, tx_p;
   logic [FRAC_W-1:0] tx_frac, tx_a;
   logic [S_W-1:0]    tx_s;
   logic              tx_wrap;

   logic [DIV_W-1:0]  rx_int, rx_p;
   logic [FRAC_W-1:0] rx_frac, rx_a;
   logic              rx_wrap;

   always_comb begin
      cfg_ok          = cfg_load && (cfg_div_int >= DIV_W'(2));
      shadow_int_nxt  = cfg_ok ? cfg_div_int  : shadow_int;
      shadow_frac_nxt = cfg_ok ? cfg_div_frac : shadow_frac;
      tx_wrap         = ({1'b0, tx_p} == last_count(tx_int, tx_frac, tx_a));
      rx_wrap         = ({1'b0, rx_p} == last_count(rx_int, rx_frac, rx_a));
   end

   assign cur_div_int  = tx_int;
   assign cur_div_frac = tx_frac;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_int  <= DEF_INT;
         shadow_frac <= DEF_FRAC;
         cfg_err     <= 1'b0;
      end else begin
         shadow_int  <= shadow_int_nxt;
         shadow_frac <= shadow_frac_nxt;
         cfg_err     <= cfg_load && !cfg_ok;
      end
   end

   // TX channel: divisor only changes when the sub-tick counter wraps, so bits are never truncated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_int  <= DEF_INT;
         tx_frac <= DEF_FRAC;
         tx_p    <= '0;
         tx_a    <= '0;
         tx_s    <= '0;
         tx_tick <= 1'b0;
      end else if (!en) begin
         tx_int  <= shadow_int;
         tx_frac <= shadow_frac;
         tx_p    <= '0;
         tx_a    <= '0;
         tx_s    <= '0;
         tx_tick <= 1'b0;
      end else if (tx_wrap) begin
         tx_p <= '0;
         tx_a <= tx_a + tx_frac;
         if (tx_s == S_LAST) begin
            tx_s    <= '0;
            tx_tick <= 1'b1;
            tx_int  <= shadow_int_nxt;
            tx_frac <= shadow_frac_nxt;
         end else begin
            tx_s    <= tx_s + S_W'(1);
            tx_tick <= 1'b0;
         end
      end else begin
         tx_p    <= tx_p + DIV_W'(1);
         tx_tick <= 1'b0;
      end
   end

   // RX channel: resync restarts the phase with a cleared accumulator and swallows a coincident tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_int     <= DEF_INT;
         rx_frac    <= DEF_FRAC;
         rx_p       <= '0;
         rx_a       <= '0;
         rx_os_tick <= 1'b0;
      end else if (!en) begin
         rx_int     <= shadow_int;
         rx_frac    <= shadow_frac;
         rx_p       <= '0;
         rx_a       <= '0;
         rx_os_tick <= 1'b0;
      end else if (rx_resync) begin
         rx_int     <= shadow_int_nxt;
         rx_frac    <= shadow_frac_nxt;
         rx_p       <= '0;
         rx_a       <= '0;
         rx_os_tick <= 1'b0;
      end else if (rx_wrap) begin
         rx_int     <= shadow_int_nxt;
         rx_frac    <= shadow_frac_nxt;
         rx_p       <= '0;
         rx_a       <= rx_a + rx_frac;
         rx_os_tick <= 1'b1;
      end else begin
         rx_p       <= rx_p + DIV_W'(1);
         rx_os_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Directed bench for uart_baud_tick_gen: tick times are logged by a monitor and
// checked against expected absolute cycle numbers queued by the stimulus.
module tb_uart_baud_tick_gen;

   localparam int LIMIT = 20000;

   logic        clk = 1'b0;
   logic        rst, en, cfg_load, rx_resync;
   logic [15:0] cfg_div_int;
   logic [3:0]  cfg_div_frac;
   logic        tx_tick, rx_os_tick, cfg_err;
   logic [15:0] cur_div_int;
   logic [3:0]  cur_div_frac;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rx_obs[$];
   int tx_obs[$];
   int rx_exp[$];
   int tx_exp[$];

   uart_baud_tick_gen #(
      .DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16), .DEF_DIV_INT(325), .DEF_DIV_FRAC(8)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
      .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .rx_resync(rx_resync),
      .tx_tick(tx_tick), .rx_os_tick(rx_os_tick), .cfg_err(cfg_err),
      .cur_div_int(cur_div_int), .cur_div_frac(cur_div_frac)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Tick log: cycle number of the rising edge that registered each pulse.
   always @(negedge clk) begin
      if (rx_os_tick) rx_obs.push_back(cyc);
      if (tx_tick)    tx_obs.push_back(cyc);
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic get_rx(output int c);
      int n = 0;
      while (rx_obs.size() == 0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (rx_obs.size() != 0) else begin
         bad++;
         $error("FAIL rx_timeout: observed=none expected=tick within %0d cycles", LIMIT);
      end
      c = (rx_obs.size() != 0) ? rx_obs.pop_front() : -1;
   endtask

   task automatic get_tx(output int c);
      int n = 0;
      while (tx_obs.size() == 0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (tx_obs.size() != 0) else begin
         bad++;
         $error("FAIL tx_timeout: observed=none expected=tick within %0d cycles", LIMIT);
      end
      c = (tx_obs.size() != 0) ? tx_obs.pop_front() : -1;
   endtask

   task automatic rx_check(input string tag);
      int c;
      get_rx(c);
      chk(tag, c, rx_exp.pop_front());
   endtask

   task automatic tx_check(input string tag);
      int c;
      get_tx(c);
      chk(tag, c, tx_exp.pop_front());
   endtask

   task automatic load(input logic [15:0] di, input logic [3:0] df);
      cfg_div_int  = di;
      cfg_div_frac = df;
      cfg_load     = 1'b1;
      @(negedge clk);
      cfg_load     = 1'b0;
   endtask

   initial begin
      int t0, t, x, r, r0, prev, c, n, tx_last;
      rst = 1'b1; en = 1'b0; cfg_load = 1'b0; rx_resync = 1'b0;
      cfg_div_int = '0; cfg_div_frac = '0;

      // Reset defaults, then two bit times at 325 + 8/16
      repeat (3) @(negedge clk);
      chk("rst_tx_tick", tx_tick, 0);
      chk("rst_rx_tick", rx_os_tick, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_div_int", cur_div_int, 325);
      chk("rst_div_frac", cur_div_frac, 8);
      rst = 1'b0;
      @(negedge clk);
      en = 1'b1;
      t0 = cyc;
      t = t0;
      for (int i = 0; i < 32; i++) begin
         t += (i % 2 == 0) ? 325 : 326;
         rx_exp.push_back(t);
      end
      tx_exp.push_back(t0 + 5208);
      tx_exp.push_back(t0 + 10416);
      for (int i = 0; i < 32; i++) rx_check("t1_rx_tick");
      tx_check("t1_tx_tick0");
      tx_check("t1_tx_tick1");
      tx_last = t0 + 10416;

      // Illegal divisor is rejected
      repeat (50) @(negedge clk);
      load(16'd1, 4'd3);
      chk("t3_cfg_err_pulse", cfg_err, 1);
      @(negedge clk);
      chk("t3_cfg_err_clear", cfg_err, 0);
      chk("t3_div_hold", cur_div_int, 325);
      tx_obs.delete();
      tx_exp.push_back(tx_last + 5208);
      tx_check("t3_tx_period");
      tx_last += 5208;
      chk("t3_div_int_after", cur_div_int, 325);
      chk("t3_div_frac_after", cur_div_frac, 8);

      // rx_resync at p=100, then on a cycle that would have ticked
      rx_obs.delete();
      tx_obs.delete();
      get_rx(r);
      repeat (100) @(negedge clk);
      rx_resync = 1'b1;
      x = cyc + 1;
      @(negedge clk);
      rx_resync = 1'b0;
      rx_exp.push_back(x + 325);
      rx_check("t4_rx_after_resync");
      n = 0;
      while (cyc < x + 650 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      rx_resync = 1'b1;
      @(negedge clk);
      rx_resync = 1'b0;
      chk("t4_wrap_suppressed", rx_os_tick, 0);
      rx_exp.push_back(x + 651 + 325);
      rx_exp.push_back(x + 651 + 325 + 326);
      rx_check("t4_rx_after_wrap_resync");
      rx_check("t4_rx_next_period");
      tx_exp.push_back(tx_last + 5208);
      tx_check("t4_tx_unaffected");
      tx_last += 5208;

      // Mid-bit load 54 + 4/16: current bit completes at old rate
      repeat (1000) @(negedge clk);
      load(16'd54, 4'd4);
      chk("t2_cur_before_boundary", cur_div_int, 325);
      t = tx_last + 5208;
      tx_exp.push_back(t);
      tx_exp.push_back(t + 868);
      tx_exp.push_back(t + 1736);
      tx_check("t2_tx_old_bit");
      chk("t2_cur_int_new", cur_div_int, 54);
      chk("t2_cur_frac_new", cur_div_frac, 4);
      while (rx_obs.size() > 0 && rx_obs[0] <= t) c = rx_obs.pop_front();
      get_rx(r0);
      prev = r0;
      for (int i = 0; i < 16; i++) begin
         get_rx(c);
         chk("t2_rx_gap_54_or_55", ((c - prev) == 54 || (c - prev) == 55), 1);
         prev = c;
      end
      chk("t2_rx_16_sum", prev - r0, 868);
      tx_check("t2_tx_bit_868_a");
      tx_check("t2_tx_bit_868_b");

      // Asynchronous reset between clock edges while a tick is high
      n = 0;
      while (!rx_os_tick && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk("t5_tick_seen_before_rst", rx_os_tick, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_rx_tick", rx_os_tick, 0);
      chk("t5_async_tx_tick", tx_tick, 0);
      chk("t5_async_cfg_err", cfg_err, 0);
      chk("t5_async_div_int", cur_div_int, 325);
      chk("t5_async_div_frac", cur_div_frac, 8);
      repeat (3) @(negedge clk);
      rx_obs.delete();
      tx_obs.delete();
      rst = 1'b0;
      rx_exp.push_back(cyc + 325);
      rx_check("t5_rx_after_release");

      // en low holds everything idle; en high restarts from scratch
      repeat (500) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      rx_obs.delete();
      tx_obs.delete();
      repeat (1000) @(negedge clk);
      chk("t6_no_rx_ticks", rx_obs.size(), 0);
      chk("t6_no_tx_ticks", tx_obs.size(), 0);
      en = 1'b1;
      t = cyc;
      rx_exp.push_back(t + 325);
      rx_exp.push_back(t + 651);
      tx_exp.push_back(t + 5208);
      rx_check("t6_rx_first");
      rx_check("t6_rx_second");
      tx_check("t6_tx_first");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
